// File: rtl/stream_buffer_pkg.sv
// rtl/stream_buffer_pkg.sv - shared element width, default depth and occupancy classes for stream_buffer
package stream_buffer_pkg;

  // Width of one stream element (intN).
  localparam int INT_N = 8;

  localparam int STREAM_BUFFER_DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  // Empty wins over full so a degenerate classification can never claim both.
  function automatic occ_e occ_classify(input logic is_empty, input logic is_full);
    if (is_empty) begin
      return OCC_EMPTY;
    end else if (is_full) begin
      return OCC_FULL;
    end else begin
      return OCC_PARTIAL;
    end
  endfunction

endpackage

// File: rtl/stream_buffer_mem.sv
// rtl/stream_buffer_mem.sv - DEPTH x N register file, one write port, one asynchronous read port
module stream_buffer_mem #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem [DEPTH];

  // Write port; contents are intentionally not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_buffer.sv
// rtl/stream_buffer.sv - elastic stream FIFO; define STREAM_BUFFER_BYPASS_EN for empty-buffer pass-through
module stream_buffer
  import stream_buffer_pkg::*;
#(
  parameter int N     = INT_N,
  parameter int DEPTH = STREAM_BUFFER_DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [N-1:0] sIn,
  input  logic         sIn_valid,
  output logic         sIn_ready,
  output logic [N-1:0] sOut,
  output logic         sOut_valid,
  input  logic         sOut_ready,
  output logic [AW:0]  count
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic [N-1:0]  head;
  occ_e          occ;
  logic          bypass;
  logic          push;
  logic          pop;

  // Occupancy class derived from the registered count.
  always_comb begin
    occ = occ_classify(count == '0, count == FULL_CNT);
  end

`ifdef STREAM_BUFFER_BYPASS_EN
  // Empty buffer with both sides ready: hand the element straight through.
  assign bypass = (occ == OCC_EMPTY) && sIn_valid && sOut_ready;
`else
  assign bypass = 1'b0;
`endif

  // A full buffer still accepts when the head leaves in the same cycle.
  assign sIn_ready  = (occ != OCC_FULL) || sOut_ready;
  assign sOut_valid = (occ != OCC_EMPTY) || bypass;
  assign sOut       = bypass ? sIn : head;

  // A bypassed element touches neither storage nor pointers.
  assign push = sIn_valid && sIn_ready && !bypass;
  assign pop  = (occ != OCC_EMPTY) && sOut_ready;

  stream_buffer_mem #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr),
    .wdata (sIn),
    .raddr (rd),
    .rdata (head)
  );

  // Pointers wrap by natural overflow; count disambiguates full from empty.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wr <= wr + 1'b1;
      end
      if (pop) begin
        rd <= rd + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_buffer.sv
// tb/tb_stream_buffer.sv - randomized scoreboard bench for stream_buffer
module tb_stream_buffer;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef STREAM_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          nrst;
  logic [N-1:0]  sIn;
  logic          sIn_valid;
  logic          sIn_ready;
  logic [N-1:0]  sOut;
  logic          sOut_valid;
  logic          sOut_ready;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  // Reference model: the buffered elements in arrival order.
  logic [N-1:0] mq[$];
  logic         cur_v;
  logic         cur_r;
  logic [N-1:0] cur_d;
  logic         e_valid;
  logic         e_ready;
  logic         e_byp;
  logic [N-1:0] e_data;
  logic [AW:0]  e_count;
  logic         acc_in;
  logic         acc_out;

  stream_buffer #(
    .N     (N),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .sIn        (sIn),
    .sIn_valid  (sIn_valid),
    .sIn_ready  (sIn_ready),
    .sOut       (sOut),
    .sOut_valid (sOut_valid),
    .sOut_ready (sOut_ready),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called one time unit after a rising edge; leaves expectations for this cycle.
  task automatic drive(input logic v, input logic [N-1:0] d, input logic r);
    cur_v = v;
    cur_d = d;
    cur_r = r;
    sIn_valid  = v;
    sIn        = d;
    sOut_ready = r;
    #1;
    e_byp   = BYP && (mq.size() == 0) && v && r;
    e_valid = (mq.size() != 0) || e_byp;
    e_data  = e_byp ? d : ((mq.size() != 0) ? mq[0] : e_data);
    e_count = (AW+1)'(mq.size());
    e_ready = (mq.size() != DEPTH) || r;
  endtask

  // Apply this cycle's handshakes to the model, then cross the rising edge.
  task automatic tick();
    acc_out = (mq.size() != 0) && cur_r && !e_byp;
    acc_in  = cur_v && e_ready && !e_byp;
    if (acc_out) void'(mq.pop_front());
    if (acc_in) mq.push_back(cur_d);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst       = 1'b0;
    sIn_valid  = 1'b1;
    sIn        = 8'hA5;
    sOut_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      checks++;
      if ({sOut_valid, sIn_ready, count} !== {1'b0, 1'b1, 3'd0}) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got valid=%0b ready=%0b count=%0d, want valid=0 ready=1 count=0",
                 i, sOut_valid, sIn_ready, count);
      end
    end
    sIn_valid = 1'b0;
    nrst      = 1'b1;
    mq.delete();
    @(posedge clk);
    #1;
    drive(1'b0, '0, 1'b0);
    checks++;
    if ({sOut_valid, count} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_no_push: got valid=%0b count=%0d, want valid=0 count=0", sOut_valid, count);
    end
    tick();
  endtask

  task automatic test_fill_drain();
    logic [N-1:0] want;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      checks++;
      if ({sOut_valid, sIn_ready, count} !== {e_valid, e_ready, e_count}) begin
        errors++;
        $display("FAIL fill[%0d]: got valid=%0b ready=%0b count=%0d, want %0b %0b %0d",
                 i, sOut_valid, sIn_ready, count, e_valid, e_ready, e_count);
      end
      tick();
    end
    for (int h = 0; h < 2; h++) begin
      drive(1'b1, 8'd5, 1'b0);
      checks++;
      if ({sIn_ready, count, sOut} !== {1'b0, 3'd4, 8'd1}) begin
        errors++;
        $display("FAIL full_hold[%0d]: got ready=%0b count=%0d sOut=%0d, want ready=0 count=4 sOut=1",
                 h, sIn_ready, count, sOut);
      end
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      drive(k == 0, 8'd5, 1'b1);
      want = 8'(k + 1);
      checks++;
      if ({sOut_valid, sOut} !== {1'b1, want}) begin
        errors++;
        $display("FAIL drain[%0d]: got valid=%0b sOut=%0d, want valid=1 sOut=%0d", k, sOut_valid, sOut, want);
      end
      tick();
    end
    drive(1'b0, '0, 1'b1);
    checks++;
    if ({sOut_valid, count} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL drain_empty: got valid=%0b count=%0d, want valid=0 count=0", sOut_valid, count);
    end
    tick();
  endtask

  task automatic test_full_simultaneous();
    logic [N-1:0] ctr;
    logic [N-1:0] want;
    ctr = 8'd10;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ctr, 1'b0);
      ctr = ctr + 8'd1;
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, ctr, 1'b1);
      want = 8'(10 + k);
      checks++;
      if ({sOut_valid, sIn_ready, count, sOut} !== {1'b1, 1'b1, 3'd4, want}) begin
        errors++;
        $display("FAIL full_stream[%0d]: got valid=%0b ready=%0b count=%0d sOut=%0d, want 1 1 4 %0d",
                 k, sOut_valid, sIn_ready, count, sOut, want);
      end
      ctr = ctr + 8'd1;
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, 1'b1);
      checks++;
      if ({sOut_valid, count, sOut} !== {e_valid, e_count, e_data}) begin
        errors++;
        $display("FAIL full_drain[%0d]: got valid=%0b count=%0d sOut=%0d, want %0b %0d %0d",
                 k, sOut_valid, count, sOut, e_valid, e_count, e_data);
      end
      tick();
    end
  endtask

  task automatic test_wrap_random();
    int cyc;
    int pushes;
    cyc    = 0;
    pushes = 0;
    while ((cyc < 37 || pushes < 36) && cyc < 300) begin
      drive($urandom_range(0, 7) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
      checks++;
      if ({sOut_valid, sIn_ready, count} !== {e_valid, e_ready, e_count} ||
          (e_valid && sOut !== e_data)) begin
        errors++;
        $display("FAIL wrap[%0d]: got valid=%0b ready=%0b count=%0d sOut=%0h, want %0b %0b %0d %0h",
                 cyc, sOut_valid, sIn_ready, count, sOut, e_valid, e_ready, e_count, e_data);
      end
      tick();
      if (acc_in) pushes++;
      cyc++;
    end
    checks++;
    if (pushes < 36) begin
      errors++;
      $display("FAIL wrap_budget: got %0d pushes, want at least 36", pushes);
    end
    for (int k = 0; k < DEPTH + 1; k++) begin
      drive(1'b0, '0, 1'b1);
      checks++;
      if ({sOut_valid, count} !== {e_valid, e_count} || (e_valid && sOut !== e_data)) begin
        errors++;
        $display("FAIL wrap_drain[%0d]: got valid=%0b count=%0d sOut=%0h, want %0b %0d %0h",
                 k, sOut_valid, count, sOut, e_valid, e_count, e_data);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'($urandom), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    checks++;
    if ({sOut_valid, count} !== {1'b1, 3'd3}) begin
      errors++;
      $display("FAIL mid_prefill: got valid=%0b count=%0d, want valid=1 count=3", sOut_valid, count);
    end
    #1;
    nrst = 1'b0;
    #1;
    checks++;
    if ({sOut_valid, count} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL mid_reset: got valid=%0b count=%0d, want valid=0 count=0", sOut_valid, count);
    end
    mq.delete();
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 8'd42, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1);
    checks++;
    if ({sOut_valid, count, sOut} !== {1'b1, 3'd1, 8'd42}) begin
      errors++;
      $display("FAIL mid_after: got valid=%0b count=%0d sOut=%0d, want valid=1 count=1 sOut=42",
               sOut_valid, count, sOut);
    end
    tick();
  endtask

  task automatic test_bypass();
    drive(1'b1, 8'd7, 1'b1);
`ifdef STREAM_BUFFER_BYPASS_EN
    checks++;
    if ({sOut_valid, sOut, count} !== {1'b1, 8'd7, 3'd0}) begin
      errors++;
      $display("FAIL bypass_same: got valid=%0b sOut=%0d count=%0d, want valid=1 sOut=7 count=0",
               sOut_valid, sOut, count);
    end
    tick();
    drive(1'b0, '0, 1'b1);
    checks++;
    if ({sOut_valid, count} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL bypass_after: got valid=%0b count=%0d, want valid=0 count=0", sOut_valid, count);
    end
    tick();
`else
    checks++;
    if ({sOut_valid, count} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL nobypass_same: got valid=%0b count=%0d, want valid=0 count=0", sOut_valid, count);
    end
    tick();
    drive(1'b0, '0, 1'b1);
    checks++;
    if ({sOut_valid, sOut, count} !== {1'b1, 8'd7, 3'd1}) begin
      errors++;
      $display("FAIL nobypass_next: got valid=%0b sOut=%0d count=%0d, want valid=1 sOut=7 count=1",
               sOut_valid, sOut, count);
    end
    tick();
`endif
  endtask

  initial begin
    e_data = '0;
    test_reset();
    test_fill_drain();
    test_full_simultaneous();
    test_wrap_random();
    test_reset_mid();
    test_bypass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/stream_buffer.md
# stream_buffer

Elastic FIFO placed directly upstream of the stream-consuming primitives (`__primitive_ap0N_*`). It decouples a stream producer from a consumer that stalls while its sync handshake is busy. Elements of width `intN` are accepted on a valid/ready handshake and delivered in order on the stream output. It holds up to DEPTH elements and reports its occupancy.

## Interface
- `N`, default `intN` (8): element width in bits.
- `DEPTH`, default 4: capacity in elements; must be a power of two, at least 2.
- `AW`, default $clog2(DEPTH): pointer width, derived; not overridden.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `nrst` in 1: asynchronous, active-low reset.
- `sIn` in N: incoming stream element.
- `sIn_valid` in 1: producer presents `sIn`.
- `sIn_ready` out 1: buffer can accept an element this cycle.
- `sOut` out N: head element.
- `sOut_valid` out 1: `sOut` holds a valid element.
- `sOut_ready` in 1: consumer takes `sOut` this cycle.
- `count` out AW+1: current occupancy, from 0 to DEPTH.

## Operation
- Push occurs when `sIn_valid && sIn_ready`. Pop occurs when `sOut_valid && sOut_ready`.
- Storage is a DEPTH-entry register array with read and write pointers `rd`/`wr`, each AW bits wide.
  - Pointers wrap modulo DEPTH by natural overflow.
  - `count` is tracked separately, so full and empty are never ambiguous.
- `sIn_ready = (count != DEPTH) || sOut_ready`.
  - Push is allowed into a full buffer when a pop happens in the same cycle.
  - This path is combinational from `sOut_ready`. Integrators must not create a loop back through `sIn_valid`.
- `sOut_valid = (count != 0)`. `sOut = mem[rd]`.
- Occupancy update:
  - Push only: `count+1`.
  - Pop only: `count-1`.
  - Both or neither: unchanged.
- A push writes `mem[wr]` and then `wr+1`. A pop advances to `rd+1`.
- Ordering is strict FIFO. Elements are never dropped or duplicated.
- Occupancy states:
  - EMPTY (`count==0`): push only.
  - PARTIAL: push and/or pop.
  - FULL (`count==DEPTH`): pop, or pop together with push.
- A push with `sIn_valid` high while `sIn_ready` is low has no effect. The producer must hold `sIn` stable until it is accepted.

## Timing
- Reset value of every output:
  - `sOut_valid=0`, `count=0`, `sIn_ready=1`.
  - `sOut` is undefined; contents are not cleared.
  - `rd=wr=0`.
- Latency without bypass: an element pushed in cycle t is visible at `sOut` with `sOut_valid=1` in cycle t+1.
- Throughput is one element per cycle in steady state at any occupancy, including FULL with simultaneous push and pop.
- Reset mid-operation: asserting `nrst` low immediately drops `sOut_valid` and zeroes `count`. Buffered elements are discarded. No handshake completes while `nrst` is low.
- Outputs are glitch-free registered values, except `sIn_ready`, which also depends on `sOut_ready`.

## Configuration
- `STREAM_BUFFER_BYPASS_EN` defined: when `count==0`, `sIn_valid=1` and `sOut_ready=1`, the element passes combinationally.
  - `sOut=sIn` and `sOut_valid=1` in the same cycle, with zero latency.
  - Storage and `count` are unchanged.
  - Otherwise behaviour is identical to the non-bypass build.
- Undefined: no combinational path from `sIn`/`sIn_valid` to `sOut`/`sOut_valid`. Minimum latency is 1 cycle.

## Structure
- `primitives.v` already carries the `stream`/`int` width definitions (`intN`) and `true`/`false`. No new typedefs are needed there.
- Add constant `STREAM_BUFFER_DEFAULT_DEPTH` (4) to the shared definitions.
- One sub-module is natural: `stream_buffer_mem`, a DEPTH×N register file with one write port and one asynchronous read port.
  - Pointer and count control stays in `stream_buffer`.

## Test plan
- **Reset:** hold `nrst=0` for 3 cycles with `sIn_valid=1` -> `sOut_valid=0`, `count=0`, `sIn_ready=1` throughout. No push is recorded.
- **Fill/drain:** `sOut_ready=0`, push 1,2,3,4 (DEPTH=4) -> `count` steps 1..4 and `sIn_ready=0` at 4. Push 5 is held. Then `sOut_ready=1` -> `sOut` = 1,2,3,4,5 on consecutive cycles.
- **Full simultaneous:** at `count=4` with `sOut_ready=1` and `sIn_valid=1`, stream 10..19 -> `count` stays 4 and output order is preserved. Also run this scenario with the bench's `sIn <= sIn + 1` counter feeding an `__primitive_ap02_llii` downstream.
- **Wrap-around:** 37 random push/pop cycles against a scoreboard -> zero mismatches. Pointers wrap at least 8 times.
- **Reset mid-stream:** `count=3`, then pulse `nrst` low mid-cycle -> `sOut_valid` falls immediately. After release, pushing 42 yields `sOut=42` next.
- **Bypass:** with the macro defined, when empty, push 7 with `sOut_ready=1` -> `sOut=7` and `sOut_valid=1` in the same cycle, `count` stays 0. Without the macro -> 7 appears next cycle.
